// File: rtl/ahbl_timer.sv
`default_nettype none
// ============================================================================
//  Module   : ahbl_timer
//  Purpose  : AHB-Lite zero-wait-state slave with a down-counting timer,
//             programmable prescaler, one-shot/periodic modes and level IRQ.
//  Revision : 1.0  initial release
// ============================================================================
module ahbl_timer #(
  parameter int CNT_W = 32,
  parameter int PRE_W = 16
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        IRQ
);

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_LOAD   = 3'd1;
  localparam logic [2:0] OFF_COUNT  = 3'd2;
  localparam logic [2:0] OFF_PRESC  = 3'd3;
  localparam logic [2:0] OFF_STATUS = 3'd4;
  localparam logic [2:0] SIZE_WORD  = 3'b010;

  // Address-phase capture
  logic [2:0]       addr_q;
  logic             write_q;
  logic             valid_q;

  // Timer registers
  logic             en_q,    en_d;
  logic             per_q,   per_d;
  logic             ie_q,    ie_d;
  logic             tof_q,   tof_d;
  logic [CNT_W-1:0] load_q,  load_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PRE_W-1:0] presc_q, presc_d;
  logic [PRE_W-1:0] pcnt_q,  pcnt_d;

  logic             wr_en;
  logic             tick;
  logic             hw_tof;
  logic [31:0]      rdata;
  logic             unused_ok;

  // Latch the address phase of a selected, active transfer; otherwise drop valid
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q  <= 3'd0;
      write_q <= 1'b0;
      valid_q <= 1'b0;
    end else if (HSEL && HTRANS[1] && HREADY) begin
      addr_q  <= HADDR[4:2];
      write_q <= HWRITE;
      valid_q <= (HSIZE == SIZE_WORD);
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign wr_en  = valid_q & write_q;
  assign tick   = en_q && (pcnt_q == presc_q);
  assign hw_tof = tick && (count_q == '0);

  // Next-state: prescaler and counter first, then bus writes override them
  always_comb begin
    en_d    = en_q;
    per_d   = per_q;
    ie_d    = ie_q;
    tof_d   = tof_q;
    load_d  = load_q;
    count_d = count_q;
    presc_d = presc_q;
    pcnt_d  = pcnt_q;

    if (!en_q || tick) begin
      pcnt_d = '0;
    end else begin
      pcnt_d = pcnt_q + PRE_W'(1);
    end

    if (tick) begin
      if (count_q != '0) begin
        count_d = count_q - CNT_W'(1);
      end else if (per_q) begin
        count_d = load_q;
      end else begin
        en_d = 1'b0;
      end
    end

    if (wr_en) begin
      case (addr_q)
        OFF_CTRL: begin
          en_d  = HWDATA[0];
          per_d = HWDATA[1];
          ie_d  = HWDATA[2];
          // A fresh enable always starts a full prescale period
          if (!en_q && HWDATA[0]) begin
            pcnt_d = '0;
          end
        end
        OFF_LOAD: begin
          load_d  = HWDATA[CNT_W-1:0];
          count_d = HWDATA[CNT_W-1:0];
          pcnt_d  = '0;
        end
        OFF_COUNT:  count_d = HWDATA[CNT_W-1:0];
        OFF_PRESC:  presc_d = HWDATA[PRE_W-1:0];
        OFF_STATUS: begin
          if (HWDATA[0]) begin
            tof_d = 1'b0;
          end
        end
        default: ;
      endcase
    end

    // Hardware overflow wins against a same-cycle clear
    if (hw_tof) begin
      tof_d = 1'b1;
    end
  end

  // Timer state registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      en_q    <= 1'b0;
      per_q   <= 1'b0;
      ie_q    <= 1'b0;
      tof_q   <= 1'b0;
      load_q  <= '0;
      count_q <= '0;
      presc_q <= '0;
      pcnt_q  <= '0;
    end else begin
      en_q    <= en_d;
      per_q   <= per_d;
      ie_q    <= ie_d;
      tof_q   <= tof_d;
      load_q  <= load_d;
      count_q <= count_d;
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
    end
  end

  // Read mux driven by the latched data-phase offset; writes and idle read 0
  always_comb begin
    rdata = '0;
    if (valid_q && !write_q) begin
      case (addr_q)
        OFF_CTRL:   rdata[2:0]       = {ie_q, per_q, en_q};
        OFF_LOAD:   rdata[CNT_W-1:0] = load_q;
        OFF_COUNT:  rdata[CNT_W-1:0] = count_q;
        OFF_PRESC:  rdata[PRE_W-1:0] = presc_q;
        OFF_STATUS: rdata[0]         = tof_q;
        default:    rdata            = '0;
      endcase
    end
  end

  assign HRDATA    = rdata;
  assign HREADYOUT = 1'b1;
  assign IRQ       = tof_q & ie_q;

  // Address/data bits outside the decoded range are intentionally ignored
  assign unused_ok = ^{HADDR[31:5], HADDR[1:0], HTRANS[0], HWDATA};

endmodule
`default_nettype wire

// File: tb/tb_ahbl_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ahbl_timer
//  Purpose  : Self-checking bench for ahbl_timer: directed scenarios plus
//             randomized bus traffic against a behavioural timer model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ahbl_timer;

  localparam logic [1:0] NS   = 2'b10;
  localparam logic [2:0] SZ_W = 3'b010;

  logic        HCLK;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        IRQ;

  int          n_tests;
  int          n_fail;
  logic [31:0] obs_rdata;
  logic        obs_irq;

  // Behavioural model: architectural registers and the pending data phase
  logic        m_en, m_per, m_ie, m_tof;
  logic [31:0] m_load, m_count;
  logic [15:0] m_presc, m_pcnt;
  logic        m_dp_v, m_dp_w;
  logic [2:0]  m_dp_off;

  ahbl_timer #(.CNT_W(32), .PRE_W(16)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HRDATA    (HRDATA),
    .HREADYOUT (HREADYOUT),
    .IRQ       (IRQ)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_per = 0; m_ie = 0; m_tof = 0;
    m_load = 0; m_count = 0; m_presc = 0; m_pcnt = 0;
    m_dp_v = 0; m_dp_w = 0; m_dp_off = 0;
  endtask

  function automatic logic [31:0] model_rd();
    if (!m_dp_v || m_dp_w) return 32'd0;
    case (m_dp_off)
      3'd0:    return {29'd0, m_ie, m_per, m_en};
      3'd1:    return m_load;
      3'd2:    return m_count;
      3'd3:    return {16'd0, m_presc};
      3'd4:    return {31'd0, m_tof};
      default: return 32'd0;
    endcase
  endfunction

  // One clock of timer behaviour, then accept the current address phase
  task automatic model_edge();
    logic        tk, w, ovf;
    logic [31:0] wd;
    logic        n_en, n_tof;
    logic [31:0] n_count;
    logic [15:0] n_pcnt;
    tk  = m_en && (m_pcnt == m_presc);
    ovf = tk && (m_count == 32'd0);
    w   = m_dp_v && m_dp_w;
    wd  = HWDATA;
    n_en = m_en; n_tof = m_tof; n_count = m_count;
    n_pcnt = (m_en && !tk) ? m_pcnt + 16'd1 : 16'd0;
    if (tk) begin
      if (!ovf) n_count = m_count - 32'd1;
      else begin
        n_tof = 1'b1;
        if (m_per) n_count = m_load;
        else       n_en = 1'b0;
      end
    end
    if (w) begin
      case (m_dp_off)
        3'd0: begin
          if (!m_en && wd[0]) n_pcnt = 16'd0;
          n_en = wd[0]; m_per = wd[1]; m_ie = wd[2];
        end
        3'd1: begin m_load = wd; n_count = wd; n_pcnt = 16'd0; end
        3'd2: n_count = wd;
        3'd3: m_presc = wd[15:0];
        3'd4: if (wd[0] && !ovf) n_tof = 1'b0;
        default: ;
      endcase
    end
    m_en = n_en; m_tof = n_tof; m_count = n_count; m_pcnt = n_pcnt;
    if (HSEL && HTRANS[1] && HREADY) begin
      m_dp_v = (HSIZE == SZ_W); m_dp_w = HWRITE; m_dp_off = HADDR[4:2];
    end else begin
      m_dp_v = 1'b0;
    end
  endtask

  // Drive one bus cycle: address phase for the next transfer, HWDATA for the current one
  task automatic cyc(input logic sel, input logic [1:0] trans, input logic wr,
                     input logic [2:0] off, input logic [2:0] size,
                     input logic [31:0] wdata, input logic rdy);
    HSEL = sel; HTRANS = trans; HWRITE = wr; HSIZE = size;
    HADDR = ($urandom & 32'hFFFF_FFE3) | {27'd0, off, 2'b00};
    HWDATA = wdata; HREADY = rdy;
    #1;
    obs_rdata = HRDATA;
    obs_irq   = IRQ;
    check_val("hrdata", HRDATA, model_rd());
    check_val("irq", {31'd0, IRQ}, {31'd0, m_tof & m_ie});
    check_val("hreadyout", {31'd0, HREADYOUT}, 32'd1);
    model_edge();
    @(posedge HCLK); #1;
  endtask

  task automatic idle(input logic [31:0] wd);
    cyc(1'b0, 2'b00, 1'b0, 3'd0, SZ_W, wd, 1'b1);
  endtask

  task automatic rd_a(input logic [2:0] off, input logic [31:0] wd);
    cyc(1'b1, NS, 1'b0, off, SZ_W, wd, 1'b1);
  endtask

  task automatic wr_a(input logic [2:0] off, input logic [31:0] wd);
    cyc(1'b1, NS, 1'b1, off, SZ_W, wd, 1'b1);
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] data);
    wr_a(off, 32'd0);
    idle(data);
  endtask

  task automatic rd(input logic [2:0] off, output logic [31:0] data);
    rd_a(off, 32'd0);
    idle(32'd0);
    data = obs_rdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int          t1, t2;
    n_tests = 0; n_fail = 0;
    HSEL = 0; HADDR = 0; HTRANS = 0; HWRITE = 0; HSIZE = SZ_W; HWDATA = 0; HREADY = 1;
    HRESETn = 1'b1;
    model_reset();

    // Reset state
    #1 HRESETn = 1'b0;
    #2;
    check_val("rst_hrdata", HRDATA, 32'd0);
    check_val("rst_irq", {31'd0, IRQ}, 32'd0);
    check_val("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rd(3'(i), v);
      check_val("rst_reg", v, 32'd0);
    end

    // One-shot: COUNT reads 3,2,1,0 then TOF/IRQ and EN clears
    wr(3'd3, 32'd0);
    wr(3'd1, 32'd3);
    wr_a(3'd0, 32'd0);
    rd_a(3'd2, 32'h5);
    for (int i = 0; i < 4; i++) begin
      rd_a(3'd2, 32'd0);
      check_val("os_count", obs_rdata, 32'(3 - i));
    end
    idle(32'd0);
    check_val("os_count_hold", obs_rdata, 32'd0);
    check_val("os_irq", {31'd0, obs_irq}, 32'd1);
    rd(3'd4, v); check_val("os_tof", v, 32'd1);
    rd(3'd0, v); check_val("os_ctrl", v, 32'h4);
    rd(3'd2, v); check_val("os_count_end", v, 32'd0);

    // Periodic: TOF every 6 cycles, W1C clears it in between
    wr(3'd4, 32'd1);
    wr(3'd3, 32'd1);
    wr(3'd1, 32'd2);
    wr_a(3'd0, 32'd0);
    rd_a(3'd4, 32'h3);
    t1 = -1;
    for (int k = 0; k < 20 && t1 < 0; k++) begin
      rd_a(3'd4, 32'd0);
      if (obs_rdata[0]) t1 = k;
    end
    check_val("per_first", 32'(t1), 32'd6);
    wr_a(3'd4, 32'd0);
    rd_a(3'd4, 32'd1);
    rd_a(3'd4, 32'd0);
    check_val("per_w1c", obs_rdata, 32'd0);
    t2 = -1;
    for (int j = 4; j < 20 && t2 < 0; j++) begin
      rd_a(3'd4, 32'd0);
      if (obs_rdata[0]) t2 = j;
    end
    check_val("per_period", 32'(t2), 32'd6);
    wr(3'd0, 32'd0);
    wr(3'd4, 32'd1);

    // Collision: W1C on the overflow cycle leaves TOF set
    wr(3'd3, 32'd0);
    wr(3'd1, 32'd2);
    wr_a(3'd0, 32'd0);
    idle(32'h1);
    idle(32'd0);
    wr_a(3'd4, 32'd0);
    rd_a(3'd4, 32'd1);
    idle(32'd0);
    check_val("col_tof", obs_rdata, 32'd1);

    // Collision: COUNT write on a tick wins over the decrement
    wr(3'd1, 32'h20);
    wr(3'd0, 32'h3);
    wr_a(3'd2, 32'd0);
    rd_a(3'd2, 32'h10);
    idle(32'd0);
    check_val("col_count", obs_rdata, 32'h10);
    wr(3'd0, 32'd0);

    // Bus protocol filtering
    wr(3'd1, 32'h7);
    cyc(1'b1, NS, 1'b1, 3'd1, 3'b000, 32'd0, 1'b1); idle(32'h55);
    rd(3'd1, v); check_val("bus_byte", v, 32'h7);
    cyc(1'b0, NS, 1'b1, 3'd1, SZ_W, 32'd0, 1'b1); idle(32'h66);
    rd(3'd1, v); check_val("bus_nosel", v, 32'h7);
    cyc(1'b1, NS, 1'b1, 3'd1, SZ_W, 32'd0, 1'b0); idle(32'h77);
    rd(3'd1, v); check_val("bus_nordy", v, 32'h7);
    wr(3'd6, 32'hFFFF_FFFF);
    rd(3'd6, v); check_val("bus_off6", v, 32'd0);
    wr_a(3'd1, 32'd0);
    rd_a(3'd1, 32'hA);
    idle(32'd0);
    check_val("bus_b2b", obs_rdata, 32'hA);

    // Randomized traffic against the model
    wr(3'd4, 32'd1);
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] wd;
      wd = ($urandom_range(0, 15) == 0) ? 32'($urandom) : (32'($urandom) & 32'h1F);
      cyc(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          3'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : SZ_W,
          wd, 1'($urandom_range(0, 7) != 0));
    end

    // Mid-run asynchronous reset with a read data phase pending
    wr(3'd3, 32'd0);
    wr(3'd1, 32'd5);
    wr(3'd0, 32'h7);
    repeat (10) idle(32'd0);
    check_val("mrst_pre_irq", {31'd0, IRQ}, 32'd1);
    rd_a(3'd2, 32'd0);
    #2 HRESETn = 1'b0;
    #1;
    check_val("mrst_hrdata", HRDATA, 32'd0);
    check_val("mrst_irq", {31'd0, IRQ}, 32'd0);
    check_val("mrst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
    model_reset();
    HSEL = 0; HTRANS = 2'b00;
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    rd(3'd2, v); check_val("mrst_count", v, 32'd0);
    rd(3'd0, v); check_val("mrst_ctrl", v, 32'd0);
    rd(3'd1, v); check_val("mrst_load", v, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
